// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands in a small FIFO, issues them one at a
// time to a registered ALU, and returns the captured results in order.
// Optional feature macro: ALU_ISSUE_TAG_EN adds a 2-bit per-command tag on res_tag.
module alu_issue_queue #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_instruction,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic [DATA_W-1:0]        inputA,
  output logic [DATA_W-1:0]        inputB,
  output logic                     instruction,
  input  logic [DATA_W-1:0]        alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
`ifdef ALU_ISSUE_TAG_EN
  output logic [1:0]               res_tag,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StExec, StCapt} state_e;

  state_e              r_state;
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [LvlW-1:0]     r_level;
  logic [DATA_W-1:0]   r_mem_a [DEPTH];
  logic [DATA_W-1:0]   r_mem_b [DEPTH];
  logic                r_mem_i [DEPTH];
  logic [DATA_W-1:0]   r_input_a;
  logic [DATA_W-1:0]   r_input_b;
  logic                r_instr;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
`ifdef ALU_ISSUE_TAG_EN
  logic [1:0]          r_mem_t [DEPTH];
  logic [1:0]          r_tag_cnt;
  logic [1:0]          r_exec_tag;
  logic [1:0]          r_res_tag;
`endif

  // Handshake and issue decisions; in_ready depends on registered level only.
  always_comb begin
    w_empty  = (r_level == '0);
    in_ready = (r_level != FullLvl);
    w_push   = in_valid && in_ready;
    // Issue only when the result slot will be free by the capture edge.
    w_pop    = (r_state == StIdle) && !w_empty && (!r_res_valid || res_ready);
  end

  // FIFO payload storage; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
      r_mem_i[r_wr_ptr] <= in_instruction;
`ifdef ALU_ISSUE_TAG_EN
      r_mem_t[r_wr_ptr] <= r_tag_cnt;
`endif
    end
  end

  // FIFO pointers, level, issue FSM, operand and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_input_a   <= '0;
      r_input_b   <= '0;
      r_instr     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
`ifdef ALU_ISSUE_TAG_EN
      r_tag_cnt   <= 2'd0;
      r_exec_tag  <= 2'd0;
      r_res_tag   <= 2'd0;
`endif
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
`ifdef ALU_ISSUE_TAG_EN
        r_tag_cnt <= r_tag_cnt + 2'd1;
`endif
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LvlW'(1);
      end

      // Consumer takes the result; a same-edge capture below overrides this.
      if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_input_a <= r_mem_a[r_rd_ptr];
            r_input_b <= r_mem_b[r_rd_ptr];
            r_instr   <= r_mem_i[r_rd_ptr];
`ifdef ALU_ISSUE_TAG_EN
            r_exec_tag <= r_mem_t[r_rd_ptr];
`endif
            r_state   <= StExec;
          end
        end
        StExec: begin
          r_state <= StCapt;
        end
        StCapt: begin
          r_res_data  <= alu_out;
          r_res_valid <= 1'b1;
`ifdef ALU_ISSUE_TAG_EN
          r_res_tag   <= r_exec_tag;
`endif
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign inputA      = r_input_a;
  assign inputB      = r_input_b;
  assign instruction = r_instr;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign fifo_level  = r_level;
`ifdef ALU_ISSUE_TAG_EN
  assign res_tag     = r_res_tag;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a scoreboard of expected ALU results.
module tb_alu_issue_queue;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_instruction;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] inputA;
  logic [DATA_W-1:0] inputB;
  logic              instruction;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef ALU_ISSUE_TAG_EN
  logic [1:0]        res_tag;
  logic [1:0]        tag_q[$];
  logic [1:0]        tb_tag;
`endif

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              rand_ready = 1'b0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instruction(in_instruction),
    .in_a          (in_a),
    .in_b          (in_b),
    .inputA        (inputA),
    .inputB        (inputB),
    .instruction   (instruction),
    .alu_out       (alu_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
`ifdef ALU_ISSUE_TAG_EN
    .res_tag       (res_tag),
`endif
    .fifo_level    (fifo_level)
  );

  // Reference 4-bit ALU: opcode 0 adds, opcode 1 subtracts.
  function automatic logic [DATA_W-1:0] alu_f(input logic i, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return i ? (a - b) : (a + b);
  endfunction

  // Registered ALU sitting behind the queue.
  always @(posedge clk) alu_out <= alu_f(instruction, inputA, inputB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepts / compare transfers at negedge, then step past posedge.
  task automatic tick();
    logic [DATA_W-1:0] e;
    @(negedge clk);
    if (reset && in_valid && in_ready) begin
      exp_q.push_back(alu_f(in_instruction, in_a, in_b));
`ifdef ALU_ISSUE_TAG_EN
      tag_q.push_back(tb_tag);
      tb_tag = tb_tag + 2'd1;
`endif
    end
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(e));
`ifdef ALU_ISSUE_TAG_EN
        chk("res_tag", 32'(res_tag), 32'(tag_q.pop_front()));
`endif
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_cmd(input logic i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic acc;
    int   n;
    in_valid       = 1'b1;
    in_instruction = i;
    in_a           = a;
    in_b           = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_checks();
    chk("rst_inputA", 32'(inputA), 32'd0);
    chk("rst_inputB", 32'(inputB), 32'd0);
    chk("rst_instruction", 32'(instruction), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset_checks();
    exp_q.delete();
`ifdef ALU_ISSUE_TAG_EN
    tag_q.delete();
    tb_tag = 2'd0;
    chk("rst_res_tag", 32'(res_tag), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_instruction = 1'b0;
    in_a           = '0;
    in_b           = '0;
    res_ready      = 1'b1;
`ifdef ALU_ISSUE_TAG_EN
    tb_tag         = 2'd0;
`endif
    #2;
    do_reset();

    // 1: single command latency.
    push_cmd(1'b0, 4'h3, 4'h5);
    chk("t1_level_after_push", 32'(fifo_level), 32'd1);
    tick();
    chk("t1_inputA", 32'(inputA), 32'h3);
    chk("t1_inputB", 32'(inputB), 32'h5);
    chk("t1_instruction", 32'(instruction), 32'd0);
    chk("t1_level_after_pop", 32'(fifo_level), 32'd0);
    tick();
    chk("t1_valid_edge2", 32'(res_valid), 32'd0);
    tick();
    chk("t1_valid_edge3", 32'(res_valid), 32'd1);
    chk("t1_res_data", 32'(res_data), 32'h8);
    drain(10);
    tick();
    chk("t1_valid_after", 32'(res_valid), 32'd0);

    // 2: fill while consumer stalls.
    res_ready = 1'b0;
    push_cmd(1'b0, 4'h1, 4'h2);
    push_cmd(1'b1, 4'h9, 4'h4);
    push_cmd(1'b0, 4'hf, 4'h1);
    push_cmd(1'b1, 4'h2, 4'h7);
    push_cmd(1'b0, 4'h6, 4'h6);
    chk("t2_level_full", 32'(fifo_level), 32'd4);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_res_valid", 32'(res_valid), 32'd1);

    // 3: hold result for 10 cycles, 6th command presented but refused.
    in_valid       = 1'b1;
    in_instruction = 1'b1;
    in_a           = 4'ha;
    in_b           = 4'hb;
    held = res_data;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_res_data_stable", 32'(res_data), 32'(held));
      chk("t3_res_valid_held", 32'(res_valid), 32'd1);
      chk("t3_level_held", 32'(fifo_level), 32'd4);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    drain(100);
    repeat (4) tick();
    chk("t2_idle_valid", 32'(res_valid), 32'd0);
    chk("t2_idle_level", 32'(fifo_level), 32'd0);

    // 4: pointer wrap under random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_cmd(1'(i), 4'(i), 4'(i + 1));
    end
    rand_ready = 1'b0;
    res_ready  = 1'b1;
    drain(200);
    repeat (4) tick();
    chk("t4_level", 32'(fifo_level), 32'd0);

    // 5: reset while a command executes with two queued.
    push_cmd(1'b0, 4'h1, 4'h1);
    push_cmd(1'b1, 4'h8, 4'h3);
    push_cmd(1'b0, 4'h4, 4'h4);
    push_cmd(1'b1, 4'h5, 4'h7);
    tick();
    chk("t5_level_exec", 32'(fifo_level), 32'd2);
    chk("t5_inputA_exec", 32'(inputA), 32'h8);
    do_reset();
    repeat (10) tick();
    chk("t5_no_result", 32'(res_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);

`ifdef ALU_ISSUE_TAG_EN
    // 6: tag sequence and reset of the tag counter.
    for (int i = 0; i < 6; i++) begin
      push_cmd(1'b0, 4'(i), 4'(2 * i));
    end
    drain(100);
    push_cmd(1'b0, 4'h1, 4'h2);
    push_cmd(1'b0, 4'h3, 4'h4);
    do_reset();
    push_cmd(1'b1, 4'h7, 4'h2);
    drain(20);
    chk("t6_tag_after_reset", 32'(res_tag), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
